// File: rtl/cpu_pkg.sv
// Shared core definitions: fetch FSM states, instruction size, RV32 opcode groups
// and a PC alignment helper used by the fetch unit.
package cpu_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        PENDING = 1'b1
    } fetch_state_t;

    localparam logic [31:0] INST_BYTES = 32'd4;

    // RV32 major opcodes (inst[6:2]); BRANCH is also decoded by the predictor.
    localparam logic [4:0] LOAD   = 5'b00000;
    localparam logic [4:0] OP_IMM = 5'b00100;
    localparam logic [4:0] AUIPC  = 5'b00101;
    localparam logic [4:0] STORE  = 5'b01000;
    localparam logic [4:0] OP     = 5'b01100;
    localparam logic [4:0] LUI    = 5'b01101;
    localparam logic [4:0] BRANCH = 5'b11000;
    localparam logic [4:0] JALR   = 5'b11001;
    localparam logic [4:0] JAL    = 5'b11011;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pc_unit.sv
// Fetch PC generator: PC register, IF/ID PC/valid register, deferred EX redirects
// while the I-side is busy, pipeline flushes and a mispredict counter.
module fetch_pc_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall_IF,
    input  logic         stall,
    input  logic         pred_jump,
    input  logic [31:0]  pc_pred,
    input  logic         t_pnt,
    input  logic         nt_pt,
    input  logic         E_jump,
    input  logic [31:0]  E_pc,
    input  logic [31:0]  E_br_target,
    input  logic [31:0]  E_jump_target,
    output logic [31:0]  pc,
    output logic [31:0]  pc_D,
    output logic         valid_D,
    output logic         pred_D,
    output logic         flush_IF_ID,
    output logic         flush_ID_EX,
    output logic [31:0]  mispredict_cnt,
    output fetch_state_t fsm_state
);

    fetch_state_t state, state_next;
    logic [31:0]  pc_next;
    logic [31:0]  pend_pc, pend_pc_next;
    logic [31:0]  redir_target;
    logic         redir;
    logic         mispredict;
    logic         flush_req;
    logic         count_en;
    logic         if_id_load;
    logic         if_id_squash;
    logic         if_id_invalidate;

    assign redir      = t_pnt | nt_pt | E_jump;
    assign mispredict = t_pnt | nt_pt;

    // Fixed priority even when several sources fire together.
    always_comb begin
        redir_target = E_jump_target;
        if (t_pnt) begin
            redir_target = E_br_target;
        end else if (nt_pt) begin
            redir_target = E_pc + INST_BYTES;
        end
        redir_target = align_pc(redir_target);
    end

    always_comb begin
        state_next       = state;
        pc_next          = pc;
        pend_pc_next     = pend_pc;
        flush_req        = 1'b0;
        count_en         = 1'b0;
        if_id_load       = 1'b0;
        if_id_squash     = 1'b0;
        if_id_invalidate = 1'b0;
        case (state)
            RUN: begin
                if (redir) begin
                    // An EX redirect beats a hazard stall; only a busy I-side defers it.
                    flush_req    = 1'b1;
                    count_en     = mispredict;
                    if_id_squash = 1'b1;
                    if (stall_IF) begin
                        state_next   = PENDING;
                        pend_pc_next = redir_target;
                    end else begin
                        pc_next = redir_target;
                    end
                end else if (!(stall || stall_IF)) begin
                    if_id_load = 1'b1;
                    pc_next    = pred_jump ? align_pc(pc_pred) : pc + INST_BYTES;
                end
            end
            PENDING: begin
                // EX is frozen behind the redirect, so its redir inputs are stale here.
                if_id_invalidate = 1'b1;
                if (!stall_IF) begin
                    pc_next    = pend_pc;
                    state_next = RUN;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    assign flush_IF_ID = flush_req & ~rst;
    assign flush_ID_EX = flush_req & ~rst;
    assign fsm_state   = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= RUN;
            pc             <= RESET_PC;
            pend_pc        <= 32'h0;
            pc_D           <= 32'h0;
            valid_D        <= 1'b0;
            pred_D         <= 1'b0;
            mispredict_cnt <= 32'h0;
        end else begin
            state   <= state_next;
            pc      <= pc_next;
            pend_pc <= pend_pc_next;
            if (count_en) begin
                mispredict_cnt <= mispredict_cnt + 32'd1;
            end
            if (if_id_squash) begin
                valid_D <= 1'b0;
                pred_D  <= 1'b0;
            end else if (if_id_invalidate) begin
                valid_D <= 1'b0;
            end else if (if_id_load) begin
                pc_D    <= pc;
                pred_D  <= pred_jump;
                valid_D <= 1'b1;
            end
        end
    end

endmodule
